fixfloat_sched: RTL and testbench

FIXFLOAT_SCHED -- requirements
Module: fixfloat_sched

---
 rtl/fixfloat_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/fixfloat_sched.sv | 134 +++++++++++++
 tb/tb_fixfloat_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fixfloat_pkg.sv
// Shared types and constants for the fixed-to-float conversion scheduler.
package fixfloat_pkg;

   localparam int DATA_W     = 32;
   localparam int FRAC_W     = 23;
   localparam int FLOAT_BIAS = 127;
   localparam int POS_W      = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      PACK = 2'd2,
      RESP = 2'd3
   } state_e;

   // Magnitude of a two's-complement word; the most negative value maps to 2^31.
   function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] d);
      return d[DATA_W-1] ? (~d + {{(DATA_W-1){1'b0}}, 1'b1}) : d;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester granted last drops to low priority.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic prio_q, prio_d;   // index of the requester currently holding priority

   // Grant the priority holder if it asks, otherwise the other one.
   always_comb begin
      grant = 2'b00;
      if (prio_q == 1'b0) begin
         if (req[0])      grant = 2'b01;
         else if (req[1]) grant = 2'b10;
      end else begin
         if (req[1])      grant = 2'b10;
         else if (req[0]) grant = 2'b01;
      end
   end

   // On an accepted grant, hand priority to the other requester.
   always_comb begin
      prio_d = prio_q;
      if (advance && (grant != 2'b00)) prio_d = grant[0];
   end

   // Priority register; reset favours requester 0.
   always_ff @(posedge clk) begin
      if (rst) prio_q <= 1'b0;
      else     prio_q <= prio_d;
   end

endmodule

// File: rtl/fixfloat_sched.sv
// Arbitrates two requesters onto one serial fixed-point to IEEE-754 single converter.
module fixfloat_sched
   import fixfloat_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [POS_W-1:0]  req0_fixpos,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [POS_W-1:0]  req1_fixpos,
   output logic              req1_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              out_id
);

   state_e            state_q, state_d;
   logic              sign_q, sign_d;
   logic [DATA_W-1:0] mag_q, mag_d;
   logic [POS_W-1:0]  fixpos_q, fixpos_d;
   logic [POS_W-1:0]  cnt_q, cnt_d;
   logic              id_q, id_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_result_q, out_result_d;
   logic              out_id_q, out_id_d;

   logic [1:0]        grant;
   logic              accept;
   logic [DATA_W-1:0] sel_data;
   logic [POS_W-1:0]  sel_fixpos;
   logic [POS_W-1:0]  leadpos;
   logic [7:0]        exp8;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     ({req1_valid, req0_valid}),
      .advance (accept),
      .grant   (grant)
   );

   // Ready only while idle, only to the granted side, never during reset.
   assign req0_ready = (state_q == IDLE) && grant[0] && !rst;
   assign req1_ready = (state_q == IDLE) && grant[1] && !rst;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign sel_data   = grant[1] ? req1_data   : req0_data;
   assign sel_fixpos = grant[1] ? req1_fixpos : req0_fixpos;

   // Leading-one position falls out of the shift count; exponent stays in 96..158.
   assign leadpos = 5'd31 - cnt_q;
   assign exp8    = 8'(FLOAT_BIAS) + {3'b000, leadpos} - {3'b000, fixpos_q};

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_id     = out_id_q;

   // Next-state logic: accept, normalise one bit per cycle, pack, hold for consumer.
   always_comb begin
      state_d      = state_q;
      sign_d       = sign_q;
      mag_d        = mag_q;
      fixpos_d     = fixpos_q;
      cnt_d        = cnt_q;
      id_d         = id_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_id_d     = out_id_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sign_d   = sel_data[DATA_W-1];
               mag_d    = abs_mag(sel_data);
               fixpos_d = sel_fixpos;
               id_d     = grant[1];
               cnt_d    = '0;
               state_d  = NORM;
            end
         end
         NORM: begin
            if ((mag_q == '0) || mag_q[DATA_W-1]) begin
               state_d = PACK;
            end else begin
               mag_d = {mag_q[DATA_W-2:0], 1'b0};
               cnt_d = cnt_q + 5'd1;
            end
         end
         PACK: begin
            // Hidden one dropped, low bits truncated; zero ignores the sign.
            out_result_d = (mag_q == '0) ? '0
                         : {sign_q, exp8, mag_q[DATA_W-2 -: FRAC_W]};
            out_id_d     = id_q;
            out_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset drops any in-flight conversion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sign_q       <= 1'b0;
         mag_q        <= '0;
         fixpos_q     <= '0;
         cnt_q        <= '0;
         id_q         <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         sign_q       <= sign_d;
         mag_q        <= mag_d;
         fixpos_q     <= fixpos_d;
         cnt_q        <= cnt_d;
         id_q         <= id_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_id_q     <= out_id_d;
      end
   end

endmodule

// File: tb/tb_fixfloat_sched.sv
// Self-checking bench for fixfloat_sched against an arithmetic reference model.
module tb_fixfloat_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_data, req1_data;
   logic [4:0]  req0_fixpos, req1_fixpos;
   logic        req0_ready, req1_ready;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_id;

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int last_gnt = -1;   // -1: nobody granted since reset
   int wait_cyc;

   fixfloat_sched dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_data   (req0_data),
      .req0_fixpos (req0_fixpos),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_data   (req1_data),
      .req1_fixpos (req1_fixpos),
      .req1_ready  (req1_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_id      (out_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Float value of d / 2^fp, truncated, built from the leading-one position.
   function automatic logic [31:0] ref_conv(input logic [31:0] d, input logic [4:0] fp,
                                            output int lat);
      longint v, mag;
      int lead, e;
      logic [31:0] frac;
      v   = longint'(signed'(d));
      mag = (v < 0) ? -v : v;
      if (mag == 0) begin
         lat = 3;
         return 32'h0;
      end
      lead = 0;
      while ((mag >> (lead + 1)) != 0) lead++;
      e = 127 + lead - int'(fp);
      if (lead >= 23) frac = 32'(mag >> (lead - 23));
      else            frac = 32'(mag << (23 - lead));
      lat = 3 + 31 - lead;
      return {(v < 0), e[7:0], frac[22:0]};
   endfunction

   // Round-robin expectation: alternate under contention, else the lone requester.
   function automatic int pick(input bit v0, input bit v1);
      if (v0 && v1) return (last_gnt == 0) ? 1 : 0;
      return v0 ? 0 : 1;
   endfunction

   // One transaction. Starts and ends just after a rising edge.
   // wres/wlat < 0 means take the expectation from the reference model.
   task automatic run_op(input bit v0, input bit v1,
                         input logic [31:0] d0, input logic [4:0] f0,
                         input logic [31:0] d1, input logic [4:0] f1,
                         input bit keep, input int hold,
                         input longint wres, input int wlat);
      int g, n, lat, t;
      logic [31:0] exp_res;
      logic [31:0] held_res;
      logic        held_id;
      req0_valid = v0; req0_data = d0; req0_fixpos = f0;
      req1_valid = v1; req1_data = d1; req1_fixpos = f1;
      wait_cyc = 0;
      @(negedge clk);
      while (1) begin
         chk("idle_no_out_valid", {31'b0, out_valid}, 32'd0);
         if (req0_ready || req1_ready || wait_cyc >= 50) break;
         wait_cyc++;
         @(negedge clk);
      end
      g = pick(v0, v1);
      chk("grant", {30'b0, req1_ready, req0_ready}, (g == 1) ? 32'd2 : 32'd1);
      if (!(req0_ready || req1_ready)) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
         @(posedge clk); #1;
         return;
      end
      n = cyc;
      last_gnt = g;
      exp_res = ref_conv(g ? d1 : d0, g ? f1 : f0, lat);
      if (wres >= 0) exp_res = wres[31:0];
      if (wlat >= 0) lat = wlat;
      @(posedge clk); #1;
      if (!keep) begin
         req0_valid = 1'b0; req1_valid = 1'b0;
      end
      // Busy phase: scramble requester data to show it is ignored.
      req0_data = $urandom; req1_data = $urandom;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 80) begin
         chk("busy_no_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
         t++;
         @(negedge clk);
      end
      chk("latency", cyc - n, lat);
      chk("result", out_result, exp_res);
      chk("out_id", {31'b0, out_id}, g);
      held_res = exp_res;
      held_id  = g[0];
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid",  {31'b0, out_valid}, 32'd1);
         chk("hold_result", out_result, held_res);
         chk("hold_id",     {31'b0, out_id}, {31'b0, held_id});
         chk("hold_ready",  {30'b0, req1_ready, req0_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int kind, lat;
      logic [31:0] rd [2];
      logic [4:0]  rf [2];
      bit v0, v1;

      // Reset state, with both requesters asking.
      rst = 1'b1; out_ready = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 32'h1234; req1_data = 32'h5678;
      req0_fixpos = 5'd3; req1_fixpos = 5'd4;
      repeat (2) @(negedge clk);
      chk("rst_out_valid",  {31'b0, out_valid}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_id",     {31'b0, out_id}, 32'd0);
      chk("rst_ready",      {30'b0, req1_ready, req0_ready}, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_gnt = -1;

      // Directed conversions with hand-derived results.
      run_op(1, 0, 32'h0001_8000, 5'd16, 32'h0, 5'd0, 0, 0, 64'h3FC0_0000, 18);
      run_op(0, 1, 32'h0, 5'd0, 32'hFFFF_0000, 5'd16, 0, 0, 64'hBF80_0000, 18);
      run_op(0, 1, 32'h0, 5'd0, 32'h8000_0000, 5'd0,  0, 0, 64'hCF00_0000, 3);
      run_op(1, 0, 32'h0, 5'd9, 32'h0, 5'd0,          0, 0, 64'h0000_0000, 3);
      run_op(0, 1, 32'h0, 5'd0, 32'h0000_0001, 5'd31, 0, 0, 64'h3000_0000, 34);

      // Consumer stalls for ten cycles.
      run_op(1, 0, 32'h1234_5678, 5'd8, 32'h0, 5'd0, 0, 10, -1, -1);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < 2; k++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
               0:       rd[k] = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h8000_0000;
               1:       rd[k] = $urandom;
               2:       rd[k] = $urandom >> $urandom_range(0, 31);
               default: rd[k] = -($urandom >> $urandom_range(1, 31));
            endcase
            rf[k] = 5'($urandom_range(0, 31));
         end
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         run_op(v0, v1, rd[0], rf[0], rd[1], rf[1], 0,
                int'($urandom_range(0, 3)), -1, -1);
      end

      // Reset during normalisation of a req0 operation (long latency).
      req0_valid = 1'b1; req0_data = 32'h1; req0_fixpos = 5'd0;
      @(negedge clk);
      chk("rstop_grant", {30'b0, req1_ready, req0_ready}, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("rstop_no_valid", {31'b0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      chk("rstop_ready_in_rst", {30'b0, req1_ready, req0_ready}, 32'd0);
      chk("rstop_valid_in_rst", {31'b0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      last_gnt = -1;

      // Continuous contention after reset: grants 0,1,0,1, regrant right after release.
      for (int i = 0; i < 4; i++) begin
         run_op(1, 1, 32'h0000_0300, 5'd4, 32'hFFFF_FF00, 5'd2, 1, 0, -1, -1);
         chk("alt_grant_seq", last_gnt, i % 2);
         chk("regrant_next_cycle", wait_cyc, 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Quiet bus stays idle.
      repeat (3) begin
         @(negedge clk);
         chk("quiet_no_valid", {31'b0, out_valid}, 32'd0);
      end
      lat = 0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
